// File: rtl/i_o_uart_tx_fifo.sv
// UART transmitter with a write FIFO, fixed baud divisor and static framing options.
// Words queued through the trigger/ready handshake are sent back to back on RXD.
module i_o_uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_BITS-1:0]                io_output_value,
    input  logic                                io_output_trigger,
    output logic                                io_output_ready_trigger,
    output logic                                io_output_idle,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     io_output_level,
    output logic                                RXD
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY == 1);

    if (DIV < 2) begin : g_div_chk
        $error("i_o_uart_tx_fifo: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
        $error("i_o_uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_chk
        $error("i_o_uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("i_o_uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("i_o_uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   rxd_q, rxd_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          count_q, count_d;
    logic                   ready_q, ready_d;
    logic                   idle_q, idle_d;
    logic                   push, pop, baud_end;
    logic [DATA_BITS-1:0]   head;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    assign head = mem[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        rxd_d    = rxd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;
        // ready is registered from the full flag alone, so a same-cycle pop never admits a push
        push     = io_output_trigger && (count_q != FULL_LVL);
        baud_end = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) pop = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    rxd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            rxd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            rxd_d   = 1'b1;
                        end
                    end else begin
                        rxd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    rxd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (count_q != '0) pop = 1'b1;
                        else               state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a pop always launches a fresh frame with a full-length start bit
        if (pop) begin
            state_d  = S_START;
            shreg_d  = head;
            par_d    = (^head) ^ ODD_PAR;
            rxd_d    = 1'b0;
            baud_d   = '0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ready_d = (count_d != FULL_LVL);
        idle_d  = (state_d == S_IDLE) && (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            rxd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            rxd_q    <= rxd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            idle_q   <= idle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= io_output_value;
    end

    assign RXD                     = rxd_q;
    assign io_output_level         = count_q;
    assign io_output_ready_trigger = ready_q;
    assign io_output_idle          = idle_q;

endmodule

// File: tb/tb_i_o_uart_tx_fifo.sv
// Directed bench for i_o_uart_tx_fifo: five instances cover 8N1, 8E1, 8O1, 8N2 and 7E1 at DIV=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_i_o_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig  [5];
    logic [7:0] val   [4];
    logic [6:0] val_e;
    logic       rxd   [5];
    logic       ready [5];
    logic       idle  [5];
    logic [2:0] level [5];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i_o_uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .io_output_value(val[0]), .io_output_trigger(trig[0]),
        .io_output_ready_trigger(ready[0]), .io_output_idle(idle[0]),
        .io_output_level(level[0]), .RXD(rxd[0]));

    i_o_uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .io_output_value(val[1]), .io_output_trigger(trig[1]),
        .io_output_ready_trigger(ready[1]), .io_output_idle(idle[1]),
        .io_output_level(level[1]), .RXD(rxd[1]));

    i_o_uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .reset(reset), .io_output_value(val[2]), .io_output_trigger(trig[2]),
        .io_output_ready_trigger(ready[2]), .io_output_idle(idle[2]),
        .io_output_level(level[2]), .RXD(rxd[2]));

    i_o_uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .reset(reset), .io_output_value(val[3]), .io_output_trigger(trig[3]),
        .io_output_ready_trigger(ready[3]), .io_output_idle(idle[3]),
        .io_output_level(level[3]), .RXD(rxd[3]));

    i_o_uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .reset(reset), .io_output_value(val_e), .io_output_trigger(trig[4]),
        .io_output_ready_trigger(ready[4]), .io_output_idle(idle[4]),
        .io_output_level(level[4]), .RXD(rxd[4]));

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            tests++;
            if ({rxd[d], ready[d], idle[d], level[d]} !== {1'b1, 1'b1, 1'b1, 3'd0}) begin
                fails++;
                $display("FAIL reset_state[%0d]: rxd=%b ready=%b idle=%b level=%0d, want 1 1 1 0",
                         d, rxd[d], ready[d], idle[d], level[d]);
            end
        end
        reset = 1'b0;
    endtask

    // One word into an empty FIFO; bit patterns are LSB-first, start bit at index 0.
    task automatic test_single_frames();
        int         sd [4] = '{0, 1, 2, 4};
        logic [7:0] sv [4] = '{8'h55, 8'h07, 8'h07, 8'h7F};
        logic [15:0] sb[4] = '{16'h02AA, 16'h060E, 16'h040E, 16'h03FE};
        int         sn [4] = '{10, 11, 11, 10};
        string      nm [4] = '{"8n1_55", "8e1_07", "8o1_07", "7e1_7f"};
        for (int e = 0; e < 4; e++) begin
            int   d;
            int   bad_at;
            logic exp_bit;
            d = sd[e];
            @(negedge clk);
            if (d == 4) val_e = sv[e][6:0];
            else        val[d] = sv[e];
            trig[d] = 1'b1;
            @(negedge clk);
            trig[d] = 1'b0;
            tests++;
            if (rxd[d] !== 1'b1 || idle[d] !== 1'b0 || level[d] !== 3'd1) begin
                fails++;
                $display("FAIL %s_push: rxd=%b idle=%b level=%0d, want 1 0 1",
                         nm[e], rxd[d], idle[d], level[d]);
            end
            bad_at = -1;
            for (int c = 0; c < sn[e] * 10; c++) begin
                @(negedge clk);
                exp_bit = sb[e][c / 10];
                if (rxd[d] !== exp_bit && bad_at < 0) bad_at = c;
            end
            tests++;
            if (bad_at >= 0) begin
                fails++;
                $display("FAIL %s_bits: first wrong rxd at clock %0d, want %b",
                         nm[e], bad_at, sb[e][bad_at / 10]);
            end
            tests++;
            if (idle[d] !== 1'b0) begin
                fails++;
                $display("FAIL %s_len: idle=%b in last stop clock, want 0", nm[e], idle[d]);
            end
            @(negedge clk);
            tests++;
            if (idle[d] !== 1'b1 || rxd[d] !== 1'b1) begin
                fails++;
                $display("FAIL %s_end: idle=%b rxd=%b, want 1 1", nm[e], idle[d], rxd[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [49:0] strm;
        int          exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
        logic        exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int          bad_at;
        int          w;
        for (int f = 0; f < 5; f++) begin
            w = f + 1;
            strm[f*10] = 1'b0;
            for (int i = 0; i < 8; i++) strm[f*10 + 1 + i] = w[i];
            strm[f*10 + 9] = 1'b1;
        end
        bad_at = -1;
        @(negedge clk);
        for (int c = 1; c <= 502; c++) begin
            if (c <= 6) begin
                val[0]  = 8'(c);
                trig[0] = 1'b1;
            end else begin
                trig[0] = 1'b0;
            end
            @(negedge clk);
            if (c <= 6) begin
                tests++;
                if (level[0] !== 3'(exp_lvl[c-1]) || ready[0] !== exp_rdy[c-1]) begin
                    fails++;
                    $display("FAIL fill_c%0d: level=%0d ready=%b, want %0d %b",
                             c, level[0], ready[0], exp_lvl[c-1], exp_rdy[c-1]);
                end
            end
            if (c >= 2 && c <= 501 && bad_at < 0 && rxd[0] !== strm[(c-2) / 10]) bad_at = c - 2;
            if (c == 101 || c == 102 || c == 202 || c == 302 || c == 402) begin
                tests++;
                if (level[0] !== 3'((c == 101) ? 4 : (4 - c / 100)) || ready[0] !== (c != 101)) begin
                    fails++;
                    $display("FAIL drain_c%0d: level=%0d ready=%b, want %0d %b",
                             c, level[0], ready[0], (c == 101) ? 4 : (4 - c / 100), c != 101);
                end
            end
            if (c == 501 || c == 502) begin
                tests++;
                if (idle[0] !== (c == 502) || rxd[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_idle_c%0d: idle=%b rxd=%b, want %b 1",
                             c, idle[0], rxd[0], c == 502);
                end
            end
        end
        tests++;
        if (bad_at >= 0) begin
            fails++;
            $display("FAIL b2b_bits: first wrong rxd at clock %0d, want %b",
                     bad_at, strm[bad_at / 10]);
        end
    endtask

    task automatic test_two_stop();
        logic [21:0] strm = 22'h3007FE;
        int          bad_at = -1;
        @(negedge clk);
        for (int c = 1; c <= 222; c++) begin
            if (c <= 2) begin
                val[3]  = (c == 1) ? 8'hFF : 8'h00;
                trig[3] = 1'b1;
            end else begin
                trig[3] = 1'b0;
            end
            @(negedge clk);
            if (c == 2 || c == 112) begin
                tests++;
                if (level[3] !== ((c == 2) ? 3'd1 : 3'd0)) begin
                    fails++;
                    $display("FAIL n2_level_c%0d: level=%0d, want %0d", c, level[3], (c == 2) ? 1 : 0);
                end
            end
            if (c >= 2 && c <= 221 && bad_at < 0 && rxd[3] !== strm[(c-2) / 10]) bad_at = c - 2;
            if (c == 221 || c == 222) begin
                tests++;
                if (idle[3] !== (c == 222)) begin
                    fails++;
                    $display("FAIL n2_idle_c%0d: idle=%b, want %b", c, idle[3], c == 222);
                end
            end
        end
        tests++;
        if (bad_at >= 0) begin
            fails++;
            $display("FAIL n2_bits: first wrong rxd at clock %0d, want %b", bad_at, strm[bad_at / 10]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fr = 10'h278;
        logic [7:0] wr [3] = '{8'hA5, 8'h11, 8'h22};
        int         bad_at = -1;
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            if (c <= 3) begin
                val[0]  = wr[c-1];
                trig[0] = 1'b1;
            end else begin
                trig[0] = 1'b0;
            end
            @(negedge clk);
        end
        tests++;
        if (rxd[0] !== 1'b0 || level[0] !== 3'd2) begin
            fails++;
            $display("FAIL pre_reset: rxd=%b level=%0d, want 0 2", rxd[0], level[0]);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (rxd[0] !== 1'b1 || level[0] !== 3'd0 || idle[0] !== 1'b1 || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: rxd=%b level=%0d idle=%b ready=%b, want 1 0 1 1",
                     rxd[0], level[0], idle[0], ready[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        val[0]  = 8'h3C;
        trig[0] = 1'b1;
        @(negedge clk);
        trig[0] = 1'b0;
        tests++;
        if (rxd[0] !== 1'b1 || level[0] !== 3'd1) begin
            fails++;
            $display("FAIL post_reset_push: rxd=%b level=%0d, want 1 1", rxd[0], level[0]);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rxd[0] !== fr[c / 10] && bad_at < 0) bad_at = c;
        end
        tests++;
        if (bad_at >= 0) begin
            fails++;
            $display("FAIL post_reset_bits: first wrong rxd at clock %0d, want %b", bad_at, fr[bad_at / 10]);
        end
        @(negedge clk);
        tests++;
        if (idle[0] !== 1'b1 || level[0] !== 3'd0) begin
            fails++;
            $display("FAIL post_reset_end: idle=%b level=%0d, want 1 0", idle[0], level[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        val_e = '0;
        for (int i = 0; i < 5; i++) trig[i] = 1'b0;
        for (int i = 0; i < 4; i++) val[i] = '0;
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_two_stop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i_o_uart_tx_fifo.md
Name: i_o_uart_tx_fifo

Overview:
Parametrised UART transmitter: the next generation of the byte-serial output controller. It adds a write FIFO, a configurable baud divisor, data width, parity mode and stop-bit count, and back-to-back framing. It sits between the CPU I/O write path and the board serial pin (RXD). The CPU pushes words through the same trigger/ready handshake as the existing output path.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate. DIV = CLK_FREQ/BAUD_RATE, integer division; DIV must be >= 2, elaboration error otherwise.
DATA_BITS, 8, payload bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, queued words, power of 2, >= 2.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
io_output_value  in  DATA_BITS  word to transmit.
io_output_trigger  in  1  write strobe, sampled on posedge clk.
io_output_ready_trigger  out  1  high when the FIFO is not full.
io_output_idle  out  1  high when the FIFO is empty and no frame is in progress.
io_output_level  out  $clog2(FIFO_DEPTH+1)  number of words currently queued (excludes the word being shifted).
RXD  out  1  serial line, idle high.

Behaviour:
- Reset (async, held): RXD=1, FIFO empty, level=0, ready=1, idle=1, state IDLE, baud counter=0, bit counter=0. RXD goes high immediately on assertion, aborting any frame mid-bit.
- Push: trigger && ready at an edge writes io_output_value; level +1 that edge.
- Trigger while full (ready=0): word dropped, no state change. Ready reflects full only; a pop in the same cycle does not make room for the push.
- Simultaneous push and pop (not full): both occur, level unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: on an edge where the FIFO is non-empty, pop into the shift register, RXD<=0, baud counter<=0, enter START. A word written at edge E into an empty FIFO therefore has its start bit from edge E+1.
- Bit timing: each bit holds RXD for exactly DIV clocks. The baud counter counts 0..DIV-1; its terminal count advances to the next bit. The counter restarts at every frame start, so the start bit is never shortened.
- START -> DATA. DATA: LSB first, DATA_BITS bits, then PARITY if PARITY != 0, else STOP.
- Parity bit: even mode = XOR of the data bits; odd mode = inverted XOR.
- STOP: RXD=1 for STOP_BITS*DIV clocks. At the end of the stop period:
  - FIFO non-empty: pop and enter START on the same edge (no idle gap).
  - FIFO empty: enter IDLE.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV clocks.
- idle = (state == IDLE) && FIFO empty. It is low from the push edge onward.
- Parameters are static; there is no runtime reconfiguration.

Test Plan:
Use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10) unless stated.
1. 8N1, FIFO empty, write 0x55 -> RXD low from the next edge. Bit sequence 0,1,0,1,0,1,0,1,0,1, 10 clocks each (100 clocks). RXD then stays high; idle returns to 1.
2. 8E1, write 0x07 -> parity bit 1; 8O1, write 0x07 -> parity bit 0. Frame is 110 clocks in both cases.
3. FIFO_DEPTH=4, write 0x01..0x06 on 6 consecutive cycles:
   - ready falls after the 5th write; 0x06 is dropped.
   - Exactly 5 frames are sent back to back: 500 clocks with no idle-high gap between the stop and start bits.
   - level steps 1,1,2,3,4, then decrements once per frame.
4. 8N2, write 0xFF then 0x00 -> first stop period is 20 clocks high, immediately followed by the next start bit.
5. Reset pulsed during data bit 3 of 0xA5 with 2 words queued -> RXD=1 asynchronously, level=0, idle=1. After release, write 0x3C: a clean full frame with a 10-clock start bit.
6. DATA_BITS=7, PARITY=2, write 0x7F -> 7 ones, parity 1, frame 100 clocks.
